uart_rx_param: RTL and testbench

Parametrised, oversampling UART receiver for the serial peripheral path. It deserialises an asynchronous `rx` line into DATA_W-bit words with configurable parity and stop bits, and checks parity and framing. Each received word is held on a valid/ready output so downstream logic can apply backpressure. It replaces the fixed 8-bit, one-sample-per-bit receiver and sits between the pad-side `rx` input and the consumer FIFO or register file.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx_param.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and legal parameter ranges for the serial peripheral path.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_e;

  localparam int unsigned DATA_W_MIN     = 5;
  localparam int unsigned DATA_W_MAX     = 9;
  localparam int unsigned OVERSAMPLE_MIN = 8;
  localparam int unsigned OVERSAMPLE_MAX = 32;
  localparam int unsigned STOP_BITS_MIN  = 1;
  localparam int unsigned STOP_BITS_MAX  = 2;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs, with selectable reset value.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: start validation, LSB-first data, optional parity,
// stop-bit framing check, and a valid/ready output register with overrun detection.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter parity_e     PARITY     = PARITY_EVEN,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic              clk_t,
  input  logic              arst_n,
  input  logic              baud_tick,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_W + 1);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("uart_rx_param: DATA_W out of range");
  end
  if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX || (OVERSAMPLE % 2) != 0)
  begin : g_bad_oversample
    $error("uart_rx_param: OVERSAMPLE must be even and in range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_rx_param: STOP_BITS out of range");
  end

  logic rx_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i  (clk_t),
    .rst_ni (arst_n),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  uart_rx_state_e    state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              armed_q, armed_d;
  logic              perr_acc_q, perr_acc_d;
  logic              ferr_acc_q, ferr_acc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              busy_q;
  logic              sample_c;
  logic              done_c;

  assign sample_c = (tick_q == TICK_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk_t or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      armed_q    <= 1'b0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      armed_q    <= armed_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  // Frame FSM; all progress is gated by baud_tick.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    done_c     = 1'b0;
    if (baud_tick) begin
      tick_d = sample_c ? '0 : tick_q + TICK_W'(1);
      unique case (state_q)
        ST_IDLE: begin
          // A line held low after a frame never re-arms until it returns high.
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d    = ST_START;
            tick_d     = '0;
            armed_d    = 1'b0;
            perr_acc_d = 1'b0;
            ferr_acc_d = 1'b0;
          end
        end
        ST_START: begin
          if (tick_q == TICK_W'(OVERSAMPLE / 2 - 1)) begin
            if (rx_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end
          end
        end
        ST_DATA: begin
          if (sample_c) begin
            shift_d = {rx_s, shift_q[DATA_W-1:1]};
            if (bit_q == BIT_W'(DATA_W - 1)) begin
              bit_d   = '0;
              state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (sample_c) begin
            perr_acc_d = rx_s ^ (^shift_q) ^ (PARITY == PARITY_ODD);
            state_d    = ST_STOP;
          end
        end
        ST_STOP: begin
          if (sample_c) begin
            ferr_acc_d = ferr_acc_q | ~rx_s;
            if (bit_q == BIT_W'(STOP_BITS - 1)) begin
              bit_d   = '0;
              state_d = ST_IDLE;
              done_c  = 1'b1;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output register: a completed frame is dropped if the previous word is still stalled.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = 1'b0;
    if (done_c) begin
      if (!valid_q || data_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        perr_d  = perr_acc_q;
        ferr_d  = ferr_acc_q | ~rx_s;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8 data bits, 16x oversampling, even parity, one stop bit.
module tb_uart_rx_param;

  logic       clk_t = 1'b0;
  logic       arst_n;
  logic       baud_tick;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  uart_rx_param #(
    .DATA_W     (8),
    .OVERSAMPLE (16),
    .PARITY     (uart_pkg::PARITY_EVEN),
    .STOP_BITS  (1)
  ) dut (
    .clk_t       (clk_t),
    .arst_n      (arst_n),
    .baud_tick   (baud_tick),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk_t = ~clk_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         cyc;
  } word_t;

  word_t dq[$];
  int    cyc   = 0;
  int    vcnt  = 0;
  int    ocnt  = 0;
  int    tests = 0;
  int    fails = 0;

  always @(posedge clk_t) cyc <= cyc + 1;

  // Record accepted words (handshake seen before the edge that consumes it).
  always @(negedge clk_t) begin
    if (data_valid) vcnt++;
    if (overrun_err) ocnt++;
    if (data_valid && data_ready) dq.push_back('{data_out, parity_err, frame_err, cyc});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk_t);
      #1;
    end
  endtask

  // Drive frame bits [first, last) of {stop, parity, data, start}, 16 clocks each.
  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop_v,
                            input int first, input int last);
    logic [10:0] f;
    f = {stop_v, (^d) ^ pflip, d, 1'b0};
    for (int i = first; i < last; i++) begin
      rx = f[i];
      wait_cyc(16);
    end
  endtask

  task automatic expect_word(input string tag, input logic [7:0] d, input logic pe,
                             input logic fe, output int wcyc);
    word_t w;
    if (dq.size() != 0) begin
      w = dq.pop_front();
    end else begin
      w = '{~d, ~pe, ~fe, -1};
    end
    wcyc = w.cyc;
    check({tag, "_data"}, 32'(w.d), 32'(d));
    check({tag, "_perr"}, 32'(w.pe), 32'(pe));
    check({tag, "_ferr"}, 32'(w.fe), 32'(fe));
  endtask

  initial begin
    int t0;
    int wc;
    int v0;
    int o0;

    arst_n     = 1'b0;
    baud_tick  = 1'b1;
    rx         = 1'b1;
    data_ready = 1'b1;
    #22;
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovr", 32'(overrun_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(posedge clk_t);
    #1;
    arst_n = 1'b1;
    wait_cyc(8);

    // Clean frame 0xA5; last stop sample lands 171 cycles after the start edge.
    v0 = vcnt;
    t0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b1, 0, 2);
    check("a5_busy_mid", 32'(busy), 32'h1);
    send_frame(8'hA5, 1'b0, 1'b1, 2, 11);
    wait_cyc(4);
    check("a5_count", 32'(dq.size()), 32'd1);
    expect_word("a5", 8'hA5, 1'b0, 1'b0, wc);
    check("a5_latency", 32'(wc - t0), 32'd171);
    check("a5_valid_cycles", 32'(vcnt - v0), 32'd1);
    check("a5_busy_after", 32'(busy), 32'h0);

    // Wrong parity bit.
    send_frame(8'h3C, 1'b1, 1'b1, 0, 11);
    wait_cyc(4);
    check("3c_count", 32'(dq.size()), 32'd1);
    expect_word("3c", 8'h3C, 1'b1, 1'b0, wc);

    // Start glitch of 4 ticks.
    v0 = vcnt;
    o0 = ocnt;
    rx = 1'b0;
    wait_cyc(4);
    check("glitch_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    wait_cyc(8);
    check("glitch_busy_clr", 32'(busy), 32'h0);
    wait_cyc(20);
    check("glitch_words", 32'(dq.size()), 32'd0);
    check("glitch_valid", 32'(vcnt - v0), 32'd0);
    check("glitch_ovr", 32'(ocnt - o0), 32'd0);

    // Framing error followed by a held break, then a clean frame.
    send_frame(8'h81, 1'b0, 1'b0, 0, 11);
    wait_cyc(264);
    check("break_busy", 32'(busy), 32'h0);
    wait_cyc(264);
    rx = 1'b1;
    wait_cyc(32);
    send_frame(8'h42, 1'b0, 1'b1, 0, 11);
    wait_cyc(4);
    check("break_count", 32'(dq.size()), 32'd2);
    expect_word("w81", 8'h81, 1'b0, 1'b1, wc);
    expect_word("w42", 8'h42, 1'b0, 1'b0, wc);

    // Overrun under backpressure.
    o0 = ocnt;
    data_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 0, 11);
    send_frame(8'h22, 1'b0, 1'b1, 0, 11);
    wait_cyc(4);
    check("ovr_data", 32'(data_out), 32'h11);
    check("ovr_valid", 32'(data_valid), 32'h1);
    check("ovr_pulses", 32'(ocnt - o0), 32'd1);
    check("ovr_words", 32'(dq.size()), 32'd0);
    data_ready = 1'b1;
    wait_cyc(3);
    check("ovr_drain_count", 32'(dq.size()), 32'd1);
    expect_word("w11", 8'h11, 1'b0, 1'b0, wc);
    check("ovr_valid_clr", 32'(data_valid), 32'h0);

    // Reset mid-DATA of 0x77.
    send_frame(8'h77, 1'b0, 1'b1, 0, 4);
    check("pre_rst_busy", 32'(busy), 32'h1);
    arst_n = 1'b0;
    rx     = 1'b1;
    #2;
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_valid", 32'(data_valid), 32'h0);
    check("mid_rst_flags", 32'({parity_err, frame_err, overrun_err}), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    wait_cyc(3);
    arst_n = 1'b1;
    wait_cyc(200);
    check("post_rst_words", 32'(dq.size()), 32'd0);
    check("post_rst_busy", 32'(busy), 32'h0);
    send_frame(8'h5A, 1'b0, 1'b1, 0, 11);
    wait_cyc(4);
    check("5a_count", 32'(dq.size()), 32'd1);
    expect_word("w5a", 8'h5A, 1'b0, 1'b0, wc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
